// File: rtl/fft_pkg.sv
// Shared types, defaults and fixed-point helpers for the FFT datapath.
// Helpers work at 64 bits; callers size-cast results to their own widths.
package fft_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_TW_WIDTH   = 16;
    localparam int TW_ONE         = 1 << (DEF_TW_WIDTH - 2);

    typedef struct packed {
        logic signed [DEF_DATA_WIDTH-1:0] re;
        logic signed [DEF_DATA_WIDTH-1:0] im;
    } cplx_t;

    // Round half up, then arithmetic shift right by sh.
    function automatic logic signed [63:0] rnd_shr(
        input logic signed [63:0] x,
        input int                 sh
    );
        logic signed [63:0] bias;
        bias = 64'sd1 <<< (sh - 1);
        return (x + bias) >>> sh;
    endfunction

    // Clamp x to the signed range of a dw-bit word.
    function automatic logic signed [63:0] sat(
        input logic signed [63:0] x,
        input int                 dw
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // True when sat() would change x.
    function automatic logic clipped(
        input logic signed [63:0] x,
        input int                 dw
    );
        return sat(x, dw) != x;
    endfunction

endpackage

// File: rtl/butterfly_r2_pipe_cmul_round.sv
// Pipelined complex multiply W*B (or conj(W)*B) with rounding.
// Three register stages; a sideband tag travels with each sample.
module cmul_round
    import fft_pkg::*;
#(
    parameter int DW    = DEF_DATA_WIDTH,
    parameter int TW    = DEF_TW_WIDTH,
    parameter int TAG_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [2*DW-1:0]   i_b,
    input  logic [2*TW-1:0]   i_w,
    input  logic              i_inverse,
    input  logic [TAG_W-1:0]  i_tag,
    output logic              o_valid,
    output logic [DW+1:0]     o_p_re,
    output logic [DW+1:0]     o_p_im,
    output logic [TAG_W-1:0]  o_tag
);

    localparam int PW = DW + TW + 1;

    logic                    r_v1, r_v2, r_v3;
    logic signed [DW-1:0]    r_b_re, r_b_im;
    logic signed [TW:0]      r_w_re, r_w_im;
    logic signed [PW-1:0]    r_rr, r_ii, r_ri, r_ir;
    logic signed [DW+1:0]    r_p_re, r_p_im;
    logic [TAG_W-1:0]        r_tag1, r_tag2, r_tag3;

    logic signed [TW:0]      w_w_re, w_w_im_raw, w_w_im;
    logic signed [PW:0]      w_s_re, w_s_im;

    // One extra bit so negating the most negative twiddle is exact.
    assign w_w_re     = (TW+1)'(signed'(i_w[2*TW-1:TW]));
    assign w_w_im_raw = (TW+1)'(signed'(i_w[TW-1:0]));
    assign w_w_im     = i_inverse ? -w_w_im_raw : w_w_im_raw;

    assign w_s_re = (PW+1)'(r_rr) - (PW+1)'(r_ii);
    assign w_s_im = (PW+1)'(r_ri) + (PW+1)'(r_ir);

    // Valid chain shifts every cycle and is cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            r_v1 <= i_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    // Data stages load only behind a valid sample, else hold.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            r_b_re <= signed'(i_b[2*DW-1:DW]);
            r_b_im <= signed'(i_b[DW-1:0]);
            r_w_re <= w_w_re;
            r_w_im <= w_w_im;
            r_tag1 <= i_tag;
        end
        if (r_v1) begin
            r_rr   <= PW'(r_w_re) * PW'(r_b_re);
            r_ii   <= PW'(r_w_im) * PW'(r_b_im);
            r_ri   <= PW'(r_w_re) * PW'(r_b_im);
            r_ir   <= PW'(r_w_im) * PW'(r_b_re);
            r_tag2 <= r_tag1;
        end
        if (r_v2) begin
            r_p_re <= (DW+2)'(rnd_shr(64'(w_s_re), TW - 2));
            r_p_im <= (DW+2)'(rnd_shr(64'(w_s_im), TW - 2));
            r_tag3 <= r_tag2;
        end
    end

    assign o_valid = r_v3;
    assign o_p_re  = r_p_re;
    assign o_p_im  = r_p_im;
    assign o_tag   = r_tag3;

endmodule

// File: rtl/butterfly_r2_pipe.sv
// Radix-2 DIT butterfly: A' = A + W*B, B' = A - W*B, 4-cycle pipeline.
// Optional halving, conjugate twiddle, saturation with overflow flags.
module butterfly_r2_pipe
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TW_WIDTH   = DEF_TW_WIDTH,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [2*DATA_WIDTH-1:0] in_a,
    input  logic [2*DATA_WIDTH-1:0] in_b,
    input  logic [2*TW_WIDTH-1:0]   w,
    input  logic [2*ADDR_WIDTH-1:0] m_in,
    input  logic                    scale_en,
    input  logic                    inverse,
    output logic                    out_valid,
    output logic [2*DATA_WIDTH-1:0] out_a,
    output logic [2*DATA_WIDTH-1:0] out_b,
    output logic [2*ADDR_WIDTH-1:0] m_out,
    output logic                    ovf,
    output logic                    ovf_sticky,
    input  logic                    ovf_clr
);

    localparam int DW    = DATA_WIDTH;
    localparam int AW    = ADDR_WIDTH;
    localparam int TAG_W = 2*DW + 2*AW + 1;

    logic                    r_out_valid;
    logic [2*DW-1:0]         r_out_a, r_out_b;
    logic [2*AW-1:0]         r_m_out;
    logic                    r_ovf, r_ovf_sticky;

    logic                    w_v3;
    logic signed [DW+1:0]    w_p_re, w_p_im;
    logic [TAG_W-1:0]        w_tag_in, w_tag;
    logic signed [DW-1:0]    w_a_re, w_a_im;
    logic [2*AW-1:0]         w_m;
    logic                    w_sc;
    logic signed [DW+1:0]    w_sa_re, w_sa_im, w_sb_re, w_sb_im;
    logic signed [63:0]      w_fa_re, w_fa_im, w_fb_re, w_fb_im;
    logic [DW-1:0]           w_ya_re, w_ya_im, w_yb_re, w_yb_im;
    logic                    w_clip;

    // A, tag and scale flag ride alongside the multiplier.
    assign w_tag_in = {in_a, m_in, scale_en};

    cmul_round #(
        .DW    (DW),
        .TW    (TW_WIDTH),
        .TAG_W (TAG_W)
    ) u_cmul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (in_valid),
        .i_b       (in_b),
        .i_w       (w),
        .i_inverse (inverse),
        .i_tag     (w_tag_in),
        .o_valid   (w_v3),
        .o_p_re    (w_p_re),
        .o_p_im    (w_p_im),
        .o_tag     (w_tag)
    );

    assign w_a_re = signed'(w_tag[TAG_W-1 -: DW]);
    assign w_a_im = signed'(w_tag[TAG_W-1-DW -: DW]);
    assign w_m    = w_tag[2*AW:1];
    assign w_sc   = w_tag[0];

    assign w_sa_re = (DW+2)'(w_a_re) + w_p_re;
    assign w_sa_im = (DW+2)'(w_a_im) + w_p_im;
    assign w_sb_re = (DW+2)'(w_a_re) - w_p_re;
    assign w_sb_im = (DW+2)'(w_a_im) - w_p_im;

    assign w_fa_re = w_sc ? rnd_shr(64'(w_sa_re), 1) : 64'(w_sa_re);
    assign w_fa_im = w_sc ? rnd_shr(64'(w_sa_im), 1) : 64'(w_sa_im);
    assign w_fb_re = w_sc ? rnd_shr(64'(w_sb_re), 1) : 64'(w_sb_re);
    assign w_fb_im = w_sc ? rnd_shr(64'(w_sb_im), 1) : 64'(w_sb_im);

    assign w_ya_re = DW'(sat(w_fa_re, DW));
    assign w_ya_im = DW'(sat(w_fa_im, DW));
    assign w_yb_re = DW'(sat(w_fb_re, DW));
    assign w_yb_im = DW'(sat(w_fb_im, DW));

    assign w_clip = clipped(w_fa_re, DW) | clipped(w_fa_im, DW) |
                    clipped(w_fb_re, DW) | clipped(w_fb_im, DW);

    // Output stage: results hold while idle, ovf only with a sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_a      <= '0;
            r_out_b      <= '0;
            r_m_out      <= '0;
            r_ovf        <= 1'b0;
            r_ovf_sticky <= 1'b0;
        end else begin
            r_out_valid <= w_v3;
            r_ovf       <= w_v3 & w_clip;
            if (w_v3) begin
                r_out_a <= {w_ya_re, w_ya_im};
                r_out_b <= {w_yb_re, w_yb_im};
                r_m_out <= w_m;
            end
            if (ovf_clr) r_ovf_sticky <= 1'b0;
            else         r_ovf_sticky <= r_ovf_sticky | (w_v3 & w_clip);
        end
    end

    assign out_valid  = r_out_valid;
    assign out_a      = r_out_a;
    assign out_b      = r_out_b;
    assign m_out      = r_m_out;
    assign ovf        = r_ovf;
    assign ovf_sticky = r_ovf_sticky;

endmodule

// File: doc/butterfly_r2_pipe.md
# butterfly_r2_pipe

Parametrised radix-2 DIT butterfly for the FFT datapath: computes A' = A + W·B and B' = A − W·B on complex samples with a fixed 4-cycle pipeline. It generalises the first-generation butterfly with a valid handshake, independent data/twiddle widths, and per-sample scaling and inverse (conjugate-twiddle) modes. Results use rounded arithmetic with saturation and an overflow flag. It sits between the stage sample memory reader and writer, carrying the write-back address alongside the data.

## Interface
- DATA_WIDTH, 16, width of each re/im data component (signed two's complement)
- TW_WIDTH, 16, width of each re/im twiddle component; format Q1.(TW_WIDTH−2), so 1.0 = 2^(TW_WIDTH−2)
- ADDR_WIDTH, 3, half-width of the sync address bus (bus is 2·ADDR_WIDTH bits)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample pair valid this cycle
- in_a  in  2·DATA_WIDTH  {re, im} of A, re in upper half
- in_b  in  2·DATA_WIDTH  {re, im} of B
- w  in  2·TW_WIDTH  {re, im} twiddle
- m_in  in  2·ADDR_WIDTH  write-back address tag
- scale_en  in  1  1 = divide results by 2 (rounded)
- inverse  in  1  1 = use conj(W)
- out_valid  out  1  results valid
- out_a, out_b  out  2·DATA_WIDTH  {re, im} results
- m_out  out  2·ADDR_WIDTH  tag aligned with results
- ovf  out  1  saturation occurred on this output sample
- ovf_sticky  out  1  OR of ovf since reset or ovf_clr
- ovf_clr  in  1  synchronous clear of ovf_sticky

## Operation
- Streaming, no backpressure; any in_valid pattern accepted, including back-to-back.
- Stage-valid bits v1..v4 shift every cycle; a stage's data registers load only when the preceding valid is 1, otherwise hold. scale_en, inverse and m_in travel with their sample.
- S1: register inputs. inverse=1 -> w_im := −w_im, computed at TW_WIDTH+1 bits so −2^(TW_WIDTH−1) is exact.
- S2: four full-precision products w_re·b_re, w_im·b_im, w_re·b_im, w_im·b_re (DATA_WIDTH+TW_WIDTH+1 bits).
- S3: p_re = w_re·b_re − w_im·b_im, p_im = w_re·b_im + w_im·b_re; round: add 2^(TW_WIDTH−3), arithmetic shift right TW_WIDTH−2; keep DATA_WIDTH+2 bits. A delayed in parallel.
- S4: s = a ± p at DATA_WIDTH+2 bits; scale_en=1 -> (s+1)>>>1 (round half up). Saturate each of 4 components to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]; ovf = any component clipped.
- ovf_sticky sets on out_valid&ovf; ovf_clr wins over a same-cycle set.

## Timing
- Latency exactly 4 cycles: in_valid at edge n -> out_valid high after edge n+4, for one cycle per sample.
- Throughput 1 sample pair/cycle.
- Outputs hold last values while out_valid=0; ovf is 0 when out_valid=0.
- Reset (async assert, any time): all valid bits, out_a, out_b, m_out, ovf, ovf_sticky = 0 immediately; in-flight samples discarded; no output for pre-reset samples after release. Internal data regs need not reset.

## Structure
- Package fft_pkg: DATA_WIDTH/TW_WIDTH defaults, TW_ONE = 2^(TW_WIDTH−2) constant, round-shift and saturate functions, complex sample struct type.
- One sub-module: cmul_round (S1–S3 complex multiply with conjugate option and rounding, 3-cycle latency, valid-in/valid-out).

## Test plan
(DATA_WIDTH=16, TW_WIDTH=16, ADDR_WIDTH=3, TW_ONE=16384)
- Reset: hold rst_n=0 with random inputs and in_valid=1 -> all outputs 0, out_valid=0.
- W=(16384,0), A=(1000,−2000), B=(300,400), m_in=6'h2A, scale_en=0 -> 4 cycles later out_a=(1300,−1600), out_b=(700,−2400), m_out=6'h2A, ovf=0.
- Same with scale_en=1 -> out_a=(650,−800), out_b=(350,−1200).
- A=0, B=(300,400), W=(0,−16384): inverse=0 -> out_a=(400,−300), out_b=(−400,300); inverse=1 -> out_a=(−400,300), out_b=(400,−300).
- A=(30000,0), B=(10000,0), W=(16384,0), scale_en=0 -> out_a=(32767,0), out_b=(20000,0), ovf=1, ovf_sticky=1 until ovf_clr pulse.
- in_valid pattern 1,1,0,1 with distinct tags, then rst_n low for 1 cycle while 2 samples are in flight -> output pattern 1,1,0,1 delayed 4 cycles before reset; out_valid drops immediately on reset; nothing emitted after release.
